mem_stage_vl: RTL and testbench

- Next-generation memory-access pipeline stage, between EX and WB, for a variable-latency data bus (req/data_ok style).
- Holds one instruction and waits for its data response when one is outstanding.
- Buffers a response that arrives while WB is stalled.
- Extracts and sign/zero-extends load data for XLEN 32 or 64.
- Drops responses that belong to flushed instructions.
- Drives the WB payload and a forwarding/bypass bundle for ID.

---
 rtl/mem_stage_vl.sv | 123 ++++++++++++
 tb/tb_mem_stage_vl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/mem_stage_vl.sv
// MEM pipeline stage for a variable-latency data bus: holds one instruction,
// waits for / buffers its response, extracts load data and drops responses of flushed ops.
module mem_stage_vl #(
  parameter int XLEN    = 32,
  parameter int PC_W    = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               ex_to_mem_valid,
  output logic               mem_allowin,
  input  logic               ex_rf_we,
  input  logic [RADDR_W-1:0] ex_rf_waddr,
  input  logic [PC_W-1:0]    ex_pc,
  input  logic [XLEN-1:0]    ex_result,
  input  logic [2:0]         ex_ld_op,
  input  logic               ex_req_issued,
  input  logic               data_sram_data_ok,
  input  logic [XLEN-1:0]    data_sram_rdata,
  input  logic               mem_flush,
  input  logic               wb_allowin,
  output logic               mem_to_wb_valid,
  output logic               mem_rf_we,
  output logic [RADDR_W-1:0] mem_rf_waddr,
  output logic [XLEN-1:0]    mem_rf_wdata,
  output logic [PC_W-1:0]    mem_pc,
  output logic               mem_fwd_we,
  output logic               mem_fwd_ready
);
  localparam int OFF_W = $clog2(XLEN/8);
  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_READY = 2'd2;

  logic               r_valid;
  logic [1:0]         r_state;
  logic [1:0]         r_cancel;
  logic [XLEN-1:0]    r_result;
  logic [XLEN-1:0]    r_rbuf;
  logic [2:0]         r_ld_op;
  logic               r_rf_we;
  logic [RADDR_W-1:0] r_waddr;
  logic [PC_W-1:0]    r_pc;

  logic               w_dok_own;
  logic               w_ready_go;
  logic               w_accept;
  logic               w_dec;
  logic [1:0]         w_inc;
  logic [XLEN-1:0]    w_raw;
  logic [XLEN-1:0]    w_sh;
  logic [XLEN-1:0]    w_ld;
  logic [OFF_W-1:0]   w_off;

  // A response belongs to the held instruction only once all cancelled ones have drained.
  assign w_dok_own  = data_sram_data_ok & (r_cancel == 2'd0);
  assign w_ready_go = (r_state == S_READY) | ((r_state == S_WAIT) & w_dok_own);
  assign mem_allowin = ~r_valid | (w_ready_go & wb_allowin);
  assign w_accept   = ex_to_mem_valid & mem_allowin & ~mem_flush;

  assign w_dec = data_sram_data_ok & (r_cancel != 2'd0);
  assign w_inc = mem_flush ? (2'((r_state == S_WAIT) & ~w_dok_own) +
                              2'(ex_to_mem_valid & ex_req_issued)) : 2'd0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_valid  <= 1'b0;
      r_state  <= S_EMPTY;
      r_cancel <= 2'd0;
    end else begin
      r_cancel <= r_cancel - {1'b0, w_dec} + w_inc;
      if (mem_flush) begin
        r_valid <= 1'b0;
        r_state <= S_EMPTY;
      end else if (mem_allowin) begin
        r_valid <= ex_to_mem_valid;
        r_state <= !ex_to_mem_valid ? S_EMPTY : (ex_req_issued ? S_WAIT : S_READY);
      end else if ((r_state == S_WAIT) & w_dok_own) begin
        r_state <= S_READY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_result <= ex_result;
      r_ld_op  <= ex_ld_op;
      r_rf_we  <= ex_rf_we;
      r_waddr  <= ex_rf_waddr;
      r_pc     <= ex_pc;
    end
    // WB stalled when our data arrived: keep it until WB takes the instruction.
    if ((r_state == S_WAIT) & w_dok_own & ~wb_allowin)
      r_rbuf <= data_sram_rdata;
  end

  assign w_off = r_result[OFF_W-1:0];
  assign w_raw = (r_state == S_READY) ? r_rbuf : data_sram_rdata;
  assign w_sh  = w_raw >> {w_off, 3'b000};

  always_comb begin
    w_ld = '0;
    case (r_ld_op)
      3'd1: w_ld = XLEN'($signed(w_sh[7:0]));
      3'd2: w_ld = XLEN'(w_sh[7:0]);
      3'd3: w_ld = XLEN'($signed(w_sh[15:0]));
      3'd4: w_ld = XLEN'(w_sh[15:0]);
      3'd5: w_ld = XLEN'($signed(w_sh[31:0]));
      3'd6: w_ld = (XLEN == 64) ? XLEN'(w_sh[31:0]) : XLEN'($signed(w_sh[31:0]));
      3'd7: w_ld = (XLEN == 64) ? w_sh : XLEN'($signed(w_sh[31:0]));
      default: w_ld = '0;
    endcase
  end

  assign mem_rf_wdata    = (r_ld_op != 3'd0) ? w_ld : r_result;
  assign mem_rf_we       = r_rf_we;
  assign mem_rf_waddr    = r_waddr;
  assign mem_pc          = r_pc;
  assign mem_to_wb_valid = r_valid & w_ready_go & ~mem_flush;
  assign mem_fwd_we      = r_valid & r_rf_we;
  assign mem_fwd_ready   = r_valid & w_ready_go;

endmodule

// File: tb/tb_mem_stage_vl.sv
// Directed bench for mem_stage_vl: XLEN=32 and XLEN=64 instances share one stimulus.
module tb_mem_stage_vl;
  logic        clk = 1'b0;
  logic        resetn;
  logic        ex_to_mem_valid, ex_rf_we, ex_req_issued, data_ok, mem_flush, wb_allowin;
  logic [4:0]  ex_rf_waddr;
  logic [31:0] ex_pc;
  logic [63:0] ex_result, rdata;
  logic [2:0]  ex_ld_op;

  logic        a32, v32, we32, fwe32, frdy32;
  logic [4:0]  wa32;
  logic [31:0] wd32, pc32;
  logic        a64, v64, we64, fwe64, frdy64;
  logic [4:0]  wa64;
  logic [63:0] wd64;
  logic [31:0] pc64;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_stage_vl #(.XLEN(32)) d32 (
    .clk(clk), .resetn(resetn), .ex_to_mem_valid(ex_to_mem_valid), .mem_allowin(a32),
    .ex_rf_we(ex_rf_we), .ex_rf_waddr(ex_rf_waddr), .ex_pc(ex_pc), .ex_result(ex_result[31:0]),
    .ex_ld_op(ex_ld_op), .ex_req_issued(ex_req_issued), .data_sram_data_ok(data_ok),
    .data_sram_rdata(rdata[31:0]), .mem_flush(mem_flush), .wb_allowin(wb_allowin),
    .mem_to_wb_valid(v32), .mem_rf_we(we32), .mem_rf_waddr(wa32), .mem_rf_wdata(wd32),
    .mem_pc(pc32), .mem_fwd_we(fwe32), .mem_fwd_ready(frdy32));

  mem_stage_vl #(.XLEN(64)) d64 (
    .clk(clk), .resetn(resetn), .ex_to_mem_valid(ex_to_mem_valid), .mem_allowin(a64),
    .ex_rf_we(ex_rf_we), .ex_rf_waddr(ex_rf_waddr), .ex_pc(ex_pc), .ex_result(ex_result),
    .ex_ld_op(ex_ld_op), .ex_req_issued(ex_req_issued), .data_sram_data_ok(data_ok),
    .data_sram_rdata(rdata), .mem_flush(mem_flush), .wb_allowin(wb_allowin),
    .mem_to_wb_valid(v64), .mem_rf_we(we64), .mem_rf_waddr(wa64), .mem_rf_wdata(wd64),
    .mem_pc(pc64), .mem_fwd_we(fwe64), .mem_fwd_ready(frdy64));

  typedef struct {
    logic [2:0]  op;
    logic [63:0] addr;
    logic [63:0] rd;
    logic [31:0] e32;
    logic [63:0] e64;
  } vec_t;
  vec_t tv[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    ex_to_mem_valid = 0; ex_rf_we = 0; ex_req_issued = 0; data_ok = 0;
    mem_flush = 0; ex_ld_op = 0;
  endtask

  task automatic issue_load(input logic [2:0] op, input logic [63:0] addr);
    ex_to_mem_valid = 1; ex_req_issued = 1; ex_rf_we = 1; ex_ld_op = op;
    ex_result = addr; ex_rf_waddr = 5'd7; ex_pc = 32'h1c00_0100;
  endtask

  initial begin
    resetn = 0; wb_allowin = 1; rdata = '0; ex_result = '0; ex_rf_waddr = '0; ex_pc = '0;
    idle();
    #12;
    chk("rst_valid", {63'd0, v32}, 64'd0);
    chk("rst_fwd_we", {63'd0, fwe32}, 64'd0);
    chk("rst_fwd_ready", {63'd0, frdy32}, 64'd0);
    chk("rst_allowin", {62'd0, a32, a64}, 64'd3);
    resetn = 1;
    tick();

    // Non-memory op: visible in MEM the cycle after acceptance.
    ex_to_mem_valid = 1; ex_rf_we = 1; ex_rf_waddr = 5'd9; ex_pc = 32'h1c00_0040;
    ex_result = 64'h1234; ex_ld_op = 0; ex_req_issued = 0;
    tick(); idle(); #1;
    chk("alu_valid", {63'd0, v32}, 64'd1);
    chk("alu_wdata", {32'd0, wd32}, 64'h1234);
    chk("alu_fwd_ready", {63'd0, frdy32}, 64'd1);
    chk("alu_fwd_we", {63'd0, fwe32}, 64'd1);
    chk("alu_waddr_pc", {27'd0, wa32, pc32}, {27'd0, 5'd9, 32'h1c00_0040});
    tick();

    tv[0] = '{3'd1, 64'd3, 64'h0000_0000_80FF_0000, 32'hFFFF_FF80, 64'hFFFF_FFFF_FFFF_FF80};
    tv[1] = '{3'd2, 64'd3, 64'h0000_0000_80FF_0000, 32'h0000_0080, 64'h0000_0000_0000_0080};
    tv[2] = '{3'd3, 64'd2, 64'h0000_0000_8001_1234, 32'hFFFF_8001, 64'hFFFF_FFFF_FFFF_8001};
    tv[3] = '{3'd4, 64'd2, 64'h0000_0000_8001_1234, 32'h0000_8001, 64'h0000_0000_0000_8001};
    tv[4] = '{3'd6, 64'd4, 64'h8000_0001_DEAD_BEEF, 32'hDEAD_BEEF, 64'h0000_0000_8000_0001};
    tv[5] = '{3'd5, 64'd4, 64'h8000_0001_DEAD_BEEF, 32'hDEAD_BEEF, 64'hFFFF_FFFF_8000_0001};
    tv[6] = '{3'd7, 64'd0, 64'h0123_4567_89AB_CDEF, 32'h89AB_CDEF, 64'h0123_4567_89AB_CDEF};
    tv[7] = '{3'd1, 64'd1, 64'h0000_0000_0000_7F00, 32'h0000_007F, 64'h0000_0000_0000_007F};
    tv[8] = '{3'd3, 64'd0, 64'h0000_0000_0000_7FFF, 32'h0000_7FFF, 64'h0000_0000_0000_7FFF};
    tv[9] = '{3'd5, 64'd0, 64'hFFFF_FFFF_7FFF_FFFF, 32'h7FFF_FFFF, 64'h0000_0000_7FFF_FFFF};

    // Each load: enter, one idle WAIT cycle, then data_ok with WB ready.
    for (int i = 0; i < 10; i++) begin
      issue_load(tv[i].op, tv[i].addr);
      tick(); idle(); #1;
      chk($sformatf("v%0d_wait", i), {62'd0, v32, v64}, 64'd0);
      tick();
      data_ok = 1; rdata = tv[i].rd; #1;
      chk($sformatf("v%0d_valid", i), {62'd0, v32, v64}, 64'd3);
      chk($sformatf("v%0d_wd32", i), {32'd0, wd32}, {32'd0, tv[i].e32});
      chk($sformatf("v%0d_wd64", i), wd64, tv[i].e64);
      tick(); data_ok = 0;
    end

    // ld.h whose data arrives while WB is stalled, then rdata changes.
    issue_load(3'd3, 64'd2);
    tick(); idle(); tick();
    wb_allowin = 0; data_ok = 1; rdata = 64'h0000_0000_8001_5555; #1;
    chk("stall_dok_valid", {63'd0, v32}, 64'd1);
    chk("stall_dok_allowin", {63'd0, a32}, 64'd0);
    tick(); data_ok = 0; rdata = 64'h1111_1111_1111_1111; #1;
    chk("stall_buf_fwd_ready", {62'd0, frdy32, frdy64}, 64'd3);
    chk("stall_buf_wd32", {32'd0, wd32}, 64'hFFFF_8001);
    tick(); #1;
    chk("stall_hold_allowin", {63'd0, a32}, 64'd0);
    wb_allowin = 1; #1;
    chk("stall_rel_valid", {62'd0, v32, v64}, 64'd3);
    chk("stall_rel_wd32", {32'd0, wd32}, 64'hFFFF_8001);
    chk("stall_rel_wd64", wd64, 64'hFFFF_FFFF_FFFF_8001);
    tick(); #1;
    chk("stall_drained", {62'd0, v32, a32}, 64'd1);

    // Flush while WAIT with an issued load in EX: two responses must be dropped.
    issue_load(3'd5, 64'd0);
    tick();
    issue_load(3'd5, 64'd0); mem_flush = 1; #1;
    chk("flush_valid", {63'd0, v32}, 64'd0);
    tick(); idle(); #1;
    chk("flush_empty", {62'd0, v32, a32}, 64'd1);
    issue_load(3'd5, 64'd0);
    tick(); idle();
    data_ok = 1; rdata = 64'hAAAA_AAAA_AAAA_AAAA; #1;
    chk("cancel1_drop", {62'd0, v32, v64}, 64'd0);
    tick(); rdata = 64'h5555_5555_5555_5555; #1;
    chk("cancel2_drop", {62'd0, v32, v64}, 64'd0);
    tick(); rdata = 64'h0000_0000_1357_9BDF; #1;
    chk("cancel3_valid", {62'd0, v32, v64}, 64'd3);
    chk("cancel3_wd32", {32'd0, wd32}, 64'h1357_9BDF);
    chk("cancel3_wd64", wd64, 64'h1357_9BDF);
    tick(); data_ok = 0; #1;
    chk("cancel_after", {62'd0, v32, a32}, 64'd1);

    // Asynchronous reset while waiting with WB stalled.
    issue_load(3'd5, 64'd0);
    tick(); idle(); wb_allowin = 0; #1;
    chk("arst_pre_allowin", {63'd0, a32}, 64'd0);
    resetn = 0; #1;
    chk("arst_valid", {62'd0, v32, v64}, 64'd0);
    chk("arst_allowin", {62'd0, a32, a64}, 64'd3);
    chk("arst_fwd", {60'd0, fwe32, frdy32, fwe64, frdy64}, 64'd0);
    #4; resetn = 1; wb_allowin = 1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
